// File: rtl/axi2mem_arb_pkg.sv
// rtl/axi2mem_arb_pkg.sv - shared types and widths for the axi2mem TCDM arbiter
package axi2mem_arb_pkg;

   localparam int DEF_ID_WIDTH   = 6;
   localparam int DEF_ADDR_WIDTH = 32;

   localparam logic [1:0] LANES_NONE = 2'b00;
   localparam logic [1:0] LANES_ALL  = 2'b11;

   // Encoding doubles as the owner_o output value.
   typedef enum logic [1:0] {
      OWNER_NONE = 2'b00,
      OWNER_RD   = 2'b01,
      OWNER_WR   = 2'b10
   } owner_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RD_OWN = 2'b01,
      S_WR_OWN = 2'b10
   } state_e;

   // Exactly one lane of a pair active: illegal on a dual-lane beat.
   function automatic logic lanes_split(input logic [1:0] v);
      return (v == 2'b01) || (v == 2'b10);
   endfunction

   function automatic owner_e state_owner(input state_e s);
      case (s)
         S_RD_OWN: return OWNER_RD;
         S_WR_OWN: return OWNER_WR;
         default:  return OWNER_NONE;
      endcase
   endfunction

   function automatic state_e owner_state(input owner_e o);
      case (o)
         OWNER_RD: return S_RD_OWN;
         OWNER_WR: return S_WR_OWN;
         default:  return S_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/axi2mem_rr_pick.sv
// rtl/axi2mem_rr_pick.sv - two-way round-robin chooser between read and write channels
module axi2mem_rr_pick
   import axi2mem_arb_pkg::*;
(
   input  logic [1:0] pend,
   input  owner_e     last_served,
   output owner_e     next_owner
);

   // pend[0] is the read channel, pend[1] the write channel.
   always_comb begin
      next_owner = OWNER_NONE;
      case (pend)
         2'b01:   next_owner = OWNER_RD;
         2'b10:   next_owner = OWNER_WR;
         2'b11:   next_owner = (last_served == OWNER_RD) ? OWNER_WR : OWNER_RD;
         default: next_owner = OWNER_NONE;
      endcase
   end

endmodule

// File: rtl/axi2mem_tcdm_arbiter.sv
// rtl/axi2mem_tcdm_arbiter.sv - burst-granular round-robin share of the dual-lane TCDM command queues
module axi2mem_tcdm_arbiter
   import axi2mem_arb_pkg::*;
#(
   parameter int ID_WIDTH   = DEF_ID_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    rd_pend_i,
   input  logic                    wr_pend_i,
   input  logic [1:0]              rd_trans_req_i,
   input  logic [2*ID_WIDTH-1:0]   rd_trans_id_i,
   input  logic [2*ADDR_WIDTH-1:0] rd_trans_add_i,
   input  logic [1:0]              rd_trans_last_i,
   output logic [1:0]              rd_trans_gnt_o,
   input  logic [1:0]              wr_trans_req_i,
   input  logic [2*ID_WIDTH-1:0]   wr_trans_id_i,
   input  logic [2*ADDR_WIDTH-1:0] wr_trans_add_i,
   input  logic [1:0]              wr_trans_last_i,
   output logic [1:0]              wr_trans_gnt_o,
   output logic [1:0]              trans_req_o,
   output logic [2*ID_WIDTH-1:0]   trans_id_o,
   output logic [2*ADDR_WIDTH-1:0] trans_add_o,
   output logic [1:0]              trans_last_o,
   output logic                    trans_we_o,
   input  logic [1:0]              trans_gnt_i,
   output logic [1:0]              owner_o,
   output logic                    err_o
);

   state_e                  state_q, state_d;
   owner_e                  last_q, last_d;
   owner_e                  owner_cur, pick_last, pick_owner;
   logic                    in_burst_q, in_burst_d;
   logic                    err_q, err_d;
   logic [1:0]              own_req, own_last, other_req;
   logic [2*ID_WIDTH-1:0]   own_id;
   logic [2*ADDR_WIDTH-1:0] own_add;
   logic                    own_pend;
   logic                    err_now, beat, last_beat;

   assign owner_cur = state_owner(state_q);

   // In IDLE neither channel owns the queues, so any request is a violation.
   always_comb begin
      own_req   = LANES_NONE;
      own_last  = LANES_NONE;
      own_id    = '0;
      own_add   = '0;
      own_pend  = 1'b0;
      other_req = LANES_NONE;
      case (state_q)
         S_RD_OWN: begin
            own_req   = rd_trans_req_i;
            own_last  = rd_trans_last_i;
            own_id    = rd_trans_id_i;
            own_add   = rd_trans_add_i;
            own_pend  = rd_pend_i;
            other_req = wr_trans_req_i;
         end
         S_WR_OWN: begin
            own_req   = wr_trans_req_i;
            own_last  = wr_trans_last_i;
            own_id    = wr_trans_id_i;
            own_add   = wr_trans_add_i;
            own_pend  = wr_pend_i;
            other_req = rd_trans_req_i;
         end
         default: begin
            other_req = rd_trans_req_i | wr_trans_req_i;
         end
      endcase
   end

   assign err_now = (other_req != LANES_NONE) || lanes_split(own_req)
                 || ((own_req == LANES_ALL) && lanes_split(own_last));

   assign beat      = (own_req == LANES_ALL) && (trans_gnt_i == LANES_ALL) && !err_now;
   assign last_beat = beat && (own_last == LANES_ALL);

   // At a burst end the finishing owner counts as last served for this pick.
   assign pick_last = last_beat ? owner_cur : last_q;

   axi2mem_rr_pick u_rr_pick (
      .pend        ({wr_pend_i, rd_pend_i}),
      .last_served (pick_last),
      .next_owner  (pick_owner)
   );

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      in_burst_d = in_burst_q;
      err_d      = err_q | err_now;
      case (state_q)
         S_IDLE: begin
            state_d = owner_state(pick_owner);
         end
         default: begin
            if (last_beat) begin
               in_burst_d = 1'b0;
               last_d     = owner_cur;
               state_d    = owner_state(pick_owner);
            end else if (beat) begin
               in_burst_d = 1'b1;
            end else if (!in_burst_q && !own_pend) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         last_q     <= OWNER_WR;
         in_burst_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         in_burst_q <= in_burst_d;
         err_q      <= err_d;
      end
   end

   // Outputs are masked while reset is held so nothing leaks from a stale owner.
   assign rd_trans_gnt_o = (!rst_i && (state_q == S_RD_OWN)) ? trans_gnt_i : LANES_NONE;
   assign wr_trans_gnt_o = (!rst_i && (state_q == S_WR_OWN)) ? trans_gnt_i : LANES_NONE;

   assign trans_req_o  = (rst_i || err_now) ? LANES_NONE : own_req;
   assign trans_id_o   = rst_i ? '0 : own_id;
   assign trans_add_o  = rst_i ? '0 : own_add;
   assign trans_last_o = rst_i ? LANES_NONE : own_last;
   assign trans_we_o   = !rst_i && (state_q == S_WR_OWN);
   assign owner_o      = rst_i ? OWNER_NONE : owner_cur;
   assign err_o        = err_q && !rst_i;

endmodule

// File: tb/tb_axi2mem_tcdm_arbiter.sv
// tb/tb_axi2mem_tcdm_arbiter.sv - self-checking bench for axi2mem_tcdm_arbiter
module tb_axi2mem_tcdm_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_pend, wr_pend;
   logic [1:0]  rd_req, wr_req, rd_last, wr_last, rd_gnt, wr_gnt;
   logic [11:0] rd_id, wr_id, t_id;
   logic [63:0] rd_add, wr_add, t_add;
   logic [1:0]  t_req, t_last, t_gnt, owner;
   logic        t_we, err;

   int errors = 0;
   int checks = 0;

   // Channel-side bookkeeping: queued burst lengths and progress per channel (1=rd, 2=wr).
   int rq[$];
   int wq[$];
   int beat_pos[3];
   int beat_tot[3];
   int burst_no[3];
   int beats_done, pushed_beats, cyc;

   // Reference arbitration state.
   int m_owner, m_ls;
   bit m_mid;

   bit         rand_bp, inj_rd;
   logic [1:0] bp_gnt;

   logic [1:0]  obs_owner, obs_rd_gnt, obs_wr_gnt, obs_req, obs_last;
   logic [11:0] obs_id;
   logic [63:0] obs_add;
   logic        obs_we, obs_err;
   logic [1:0]  exp_owner, exp_rd_gnt, exp_wr_gnt, exp_req, exp_last;
   logic [11:0] exp_id;
   logic [63:0] exp_add;
   logic        exp_we;

   axi2mem_tcdm_arbiter #(.ID_WIDTH(6), .ADDR_WIDTH(32)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .rd_pend_i       (rd_pend),
      .wr_pend_i       (wr_pend),
      .rd_trans_req_i  (rd_req),
      .rd_trans_id_i   (rd_id),
      .rd_trans_add_i  (rd_add),
      .rd_trans_last_i (rd_last),
      .rd_trans_gnt_o  (rd_gnt),
      .wr_trans_req_i  (wr_req),
      .wr_trans_id_i   (wr_id),
      .wr_trans_add_i  (wr_add),
      .wr_trans_last_i (wr_last),
      .wr_trans_gnt_o  (wr_gnt),
      .trans_req_o     (t_req),
      .trans_id_o      (t_id),
      .trans_add_o     (t_add),
      .trans_last_o    (t_last),
      .trans_we_o      (t_we),
      .trans_gnt_i     (t_gnt),
      .owner_o         (owner),
      .err_o           (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int qsz(input int ch);
      return (ch == 1) ? rq.size() : wq.size();
   endfunction

   function automatic int qfront(input int ch);
      return (ch == 1) ? rq[0] : wq[0];
   endfunction

   function automatic logic [11:0] id_of(input int ch);
      logic [5:0] b;
      b = 6'(burst_no[ch] + ((ch == 2) ? 32 : 0));
      return {b, b};
   endfunction

   function automatic logic [63:0] add_of(input int ch);
      logic [31:0] a;
      a = ((ch == 1) ? 32'h0000_0100 : 32'h8000_0000) + 32'(beat_tot[ch] * 8);
      return {a + 32'd4, a};
   endfunction

   function automatic logic [1:0] last_of(input int ch);
      return (beat_pos[ch] + 1 == qfront(ch)) ? 2'b11 : 2'b00;
   endfunction

   function automatic int rr(input bit rp, input bit wp, input int ls);
      if (rp && wp) return (ls == 1) ? 2 : 1;
      if (rp) return 1;
      if (wp) return 2;
      return 0;
   endfunction

   function automatic logic [1:0] bp_choice();
      case ($urandom_range(0, 7))
         0:       return 2'b01;
         1:       return 2'b10;
         2:       return 2'b00;
         default: return 2'b11;
      endcase
   endfunction

   task automatic push_burst(input int ch, input int len);
      if (ch == 1) rq.push_back(len);
      else wq.push_back(len);
      pushed_beats += len;
   endtask

   // A channel requests both lanes whenever it holds a full grant; its pend
   // covers bursts whose first beat has not yet been accepted.
   task automatic drive_ch(input int ch);
      logic [1:0] g;
      int  n;
      bit  req_on, started, p;
      g       = (ch == 1) ? rd_gnt : wr_gnt;
      n       = qsz(ch);
      req_on  = (g == 2'b11) && (n > 0);
      started = (n > 0) && ((beat_pos[ch] > 0) || req_on);
      p       = (n - (started ? 1 : 0)) > 0;
      if (ch == 1) begin
         rd_pend = p;
         rd_req  = req_on ? 2'b11 : 2'b00;
         rd_id   = req_on ? id_of(1) : '0;
         rd_add  = req_on ? add_of(1) : '0;
         rd_last = req_on ? last_of(1) : 2'b00;
      end else begin
         wr_pend = p;
         wr_req  = req_on ? 2'b11 : 2'b00;
         wr_id   = req_on ? id_of(2) : '0;
         wr_add  = req_on ? add_of(2) : '0;
         wr_last = req_on ? last_of(2) : 2'b00;
      end
   endtask

   task automatic cycle();
      bit m_beat, is_last, rp, wp;
      t_gnt = rand_bp ? bp_choice() : bp_gnt;
      #1;
      drive_ch(1);
      drive_ch(2);
      if (inj_rd) begin
         rd_req  = 2'b11;
         rd_last = 2'b11;
         rd_add  = 64'h0000_0BAD_0000_0BAD;
      end
      #1;
      obs_owner = owner; obs_rd_gnt = rd_gnt; obs_wr_gnt = wr_gnt;
      obs_req = t_req; obs_id = t_id; obs_add = t_add; obs_last = t_last;
      obs_we = t_we; obs_err = err;
      m_beat     = (m_owner != 0) && (t_gnt == 2'b11) && (qsz(m_owner) > 0);
      exp_owner  = 2'(m_owner);
      exp_rd_gnt = (m_owner == 1) ? t_gnt : 2'b00;
      exp_wr_gnt = (m_owner == 2) ? t_gnt : 2'b00;
      exp_we     = (m_owner == 2);
      exp_req    = m_beat ? 2'b11 : 2'b00;
      exp_id     = m_beat ? id_of(m_owner) : '0;
      exp_add    = m_beat ? add_of(m_owner) : '0;
      exp_last   = m_beat ? last_of(m_owner) : 2'b00;
      rp = rd_pend;
      wp = wr_pend;
      is_last = m_beat && (exp_last == 2'b11);
      if (m_beat) begin
         beats_done++;
         beat_tot[m_owner]++;
         if (is_last) begin
            if (m_owner == 1) void'(rq.pop_front());
            else void'(wq.pop_front());
            beat_pos[m_owner] = 0;
            burst_no[m_owner]++;
         end else begin
            beat_pos[m_owner]++;
         end
      end
      if (m_owner == 0) begin
         m_owner = rr(rp, wp, m_ls);
      end else if (is_last) begin
         m_mid   = 1'b0;
         m_ls    = m_owner;
         m_owner = rr(rp, wp, m_ls);
      end else if (m_beat) begin
         m_mid = 1'b1;
      end else if (!m_mid && !((m_owner == 1) ? rp : wp)) begin
         m_owner = 0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      rd_pend = 0; wr_pend = 0;
      rd_req = 0; wr_req = 0; rd_last = 0; wr_last = 0;
      rd_id = 0; wr_id = 0; rd_add = 0; wr_add = 0;
      t_gnt = 0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      zero_inputs();
      rq.delete();
      wq.delete();
      for (int i = 0; i < 3; i++) begin
         beat_pos[i] = 0; beat_tot[i] = 0; burst_no[i] = 0;
      end
      beats_done = 0; pushed_beats = 0; cyc = 0;
      m_owner = 0; m_ls = 2; m_mid = 1'b0;
      rand_bp = 1'b0; inj_rd = 1'b0; bp_gnt = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      zero_inputs();
      rd_pend = 1; wr_pend = 1; rd_req = 2'b11; wr_req = 2'b11; rd_last = 2'b11; t_gnt = 2'b11;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (rd_gnt !== 2'b00) begin errors++; $display("FAIL reset_rd_gnt got=%b exp=00", rd_gnt); end
      checks++; if (wr_gnt !== 2'b00) begin errors++; $display("FAIL reset_wr_gnt got=%b exp=00", wr_gnt); end
      checks++; if (t_req !== 2'b00) begin errors++; $display("FAIL reset_req got=%b exp=00", t_req); end
      checks++; if (t_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", t_we); end
      checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got=%b exp=00", owner); end
      reset_dut();
      #1;
      checks++; if (owner !== 2'b00) begin errors++; $display("FAIL post_reset_owner got=%b exp=00", owner); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL post_reset_err got=%b exp=0", err); end
      checks++; if (rd_gnt !== 2'b00) begin errors++; $display("FAIL post_reset_rd_gnt got=%b exp=00", rd_gnt); end
   endtask

   task automatic test_read_single();
      reset_dut();
      push_burst(1, 1);
      cycle();
      checks++; if (obs_owner !== 2'b00) begin errors++; $display("FAIL single_c0_owner got=%b exp=00", obs_owner); end
      checks++; if (obs_rd_gnt !== 2'b00) begin errors++; $display("FAIL single_c0_gnt got=%b exp=00", obs_rd_gnt); end
      cycle();
      checks++; if (obs_owner !== 2'b01) begin errors++; $display("FAIL single_c1_owner got=%b exp=01", obs_owner); end
      checks++; if (obs_rd_gnt !== 2'b11) begin errors++; $display("FAIL single_c1_gnt got=%b exp=11", obs_rd_gnt); end
      checks++; if (obs_req !== 2'b11) begin errors++; $display("FAIL single_c1_req got=%b exp=11", obs_req); end
      checks++; if (obs_add !== 64'h0000_0104_0000_0100) begin errors++; $display("FAIL single_c1_add got=%h exp=0000010400000100", obs_add); end
      checks++; if (obs_last !== 2'b11) begin errors++; $display("FAIL single_c1_last got=%b exp=11", obs_last); end
      checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL single_c1_we got=%b exp=0", obs_we); end
      cycle();
      checks++; if (obs_owner !== 2'b00) begin errors++; $display("FAIL single_c2_owner got=%b exp=00", obs_owner); end
      checks++; if (obs_req !== 2'b00) begin errors++; $display("FAIL single_c2_req got=%b exp=00", obs_req); end
   endtask

   task automatic test_contention();
      reset_dut();
      push_burst(1, 2);
      push_burst(1, 2);
      push_burst(2, 4);
      for (int c = 0; c < 12; c++) begin
         cycle();
         checks++; if (obs_owner !== exp_owner) begin errors++; $display("FAIL cont_owner c%0d got=%b exp=%b", c, obs_owner, exp_owner); end
         checks++; if (obs_req !== exp_req) begin errors++; $display("FAIL cont_req c%0d got=%b exp=%b", c, obs_req, exp_req); end
         if (c == 1) begin
            checks++; if (obs_owner !== 2'b01) begin errors++; $display("FAIL cont_first_read got=%b exp=01", obs_owner); end
         end
         if (c == 3) begin
            checks++; if (obs_wr_gnt !== 2'b11 || obs_we !== 1'b1) begin errors++; $display("FAIL cont_write_next gnt=%b we=%b exp gnt=11 we=1", obs_wr_gnt, obs_we); end
         end
         if (c == 7) begin
            checks++; if (obs_owner !== 2'b01) begin errors++; $display("FAIL cont_read_again got=%b exp=01", obs_owner); end
         end
      end
      checks++; if (beats_done !== 8) begin errors++; $display("FAIL cont_beats got=%0d exp=8", beats_done); end
   endtask

   task automatic test_no_preempt();
      reset_dut();
      push_burst(2, 8);
      cycle();
      push_burst(1, 2);
      for (int b = 0; b < 8; b++) begin
         cycle();
         checks++; if (obs_rd_gnt !== 2'b00) begin errors++; $display("FAIL nopre_rd_gnt beat%0d got=%b exp=00", b, obs_rd_gnt); end
         checks++; if (obs_wr_gnt !== 2'b11 || obs_req !== 2'b11) begin errors++; $display("FAIL nopre_wr beat%0d gnt=%b req=%b exp 11/11", b, obs_wr_gnt, obs_req); end
         checks++; if (obs_add !== exp_add || obs_last !== exp_last) begin errors++; $display("FAIL nopre_data beat%0d add=%h last=%b exp %h/%b", b, obs_add, obs_last, exp_add, exp_last); end
      end
      cycle();
      checks++; if (obs_owner !== 2'b01) begin errors++; $display("FAIL nopre_read_after got=%b exp=01", obs_owner); end
   endtask

   task automatic test_backpressure();
      logic [1:0] pat [9];
      pat = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
      reset_dut();
      push_burst(1, 4);
      for (int c = 0; c < 9; c++) begin
         bp_gnt = pat[c];
         cycle();
         if (c > 0) begin
            checks++; if (obs_rd_gnt !== pat[c]) begin errors++; $display("FAIL bp_gnt c%0d got=%b exp=%b", c, obs_rd_gnt, pat[c]); end
         end
         checks++; if (obs_req !== exp_req || (exp_req == 2'b11 && obs_add !== exp_add)) begin errors++; $display("FAIL bp_beat c%0d req=%b add=%h exp %b/%h", c, obs_req, obs_add, exp_req, exp_add); end
      end
      checks++; if (beats_done !== 4 || obs_last !== 2'b11) begin errors++; $display("FAIL bp_total beats=%0d last=%b exp 4/11", beats_done, obs_last); end
   endtask

   task automatic test_protocol_error();
      reset_dut();
      push_burst(2, 4);
      cycle();
      cycle();
      bp_gnt = 2'b00;
      inj_rd = 1'b1;
      cycle();
      checks++; if (obs_req !== 2'b00) begin errors++; $display("FAIL perr_forward got=%b exp=00", obs_req); end
      checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL perr_early got=%b exp=0", obs_err); end
      inj_rd = 1'b0;
      bp_gnt = 2'b11;
      cycle();
      checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL perr_set got=%b exp=1", obs_err); end
      repeat (6) cycle();
      checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b exp=1", obs_err); end
      reset_dut();
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL perr_cleared got=%b exp=0", err); end
   endtask

   task automatic test_reset_mid_burst();
      reset_dut();
      push_burst(2, 8);
      repeat (4) cycle();
      checks++; if (beats_done !== 3) begin errors++; $display("FAIL rstmid_beats got=%0d exp=3", beats_done); end
      rst = 1'b1;
      wr_pend = 1'b1;
      @(posedge clk);
      #2;
      checks++; if (t_req !== 2'b00 || t_add !== '0 || t_id !== '0 || t_last !== 2'b00) begin errors++; $display("FAIL rstmid_cmd req=%b add=%h id=%h last=%b exp zero", t_req, t_add, t_id, t_last); end
      checks++; if (rd_gnt !== 2'b00 || wr_gnt !== 2'b00 || t_we !== 1'b0) begin errors++; $display("FAIL rstmid_gnt rd=%b wr=%b we=%b exp 00/00/0", rd_gnt, wr_gnt, t_we); end
      checks++; if (owner !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL rstmid_owner owner=%b err=%b exp 00/0", owner, err); end
      zero_inputs();
      rst = 1'b0;
      @(posedge clk);
      #2;
      checks++; if (owner !== 2'b00 || t_req !== 2'b00) begin errors++; $display("FAIL rstmid_after owner=%b req=%b exp 00/00", owner, t_req); end
   endtask

   task automatic test_random();
      int c;
      reset_dut();
      rand_bp = 1'b1;
      c = 0;
      while (c < 1400) begin
         if (c < 600) begin
            if (rq.size() < 4 && $urandom_range(0, 5) == 0) push_burst(1, $urandom_range(1, 8));
            if (wq.size() < 4 && $urandom_range(0, 5) == 0) push_burst(2, $urandom_range(1, 8));
         end else if (rq.size() == 0 && wq.size() == 0 && m_owner == 0) begin
            break;
         end
         cycle();
         checks++; if (obs_owner !== exp_owner) begin errors++; $display("FAIL rand_owner c%0d got=%b exp=%b", c, obs_owner, exp_owner); end
         checks++; if (obs_rd_gnt !== exp_rd_gnt) begin errors++; $display("FAIL rand_rd_gnt c%0d got=%b exp=%b", c, obs_rd_gnt, exp_rd_gnt); end
         checks++; if (obs_wr_gnt !== exp_wr_gnt) begin errors++; $display("FAIL rand_wr_gnt c%0d got=%b exp=%b", c, obs_wr_gnt, exp_wr_gnt); end
         checks++; if (obs_req !== exp_req) begin errors++; $display("FAIL rand_req c%0d got=%b exp=%b", c, obs_req, exp_req); end
         checks++; if (obs_we !== exp_we) begin errors++; $display("FAIL rand_we c%0d got=%b exp=%b", c, obs_we, exp_we); end
         checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL rand_err c%0d got=%b exp=0", c, obs_err); end
         if (exp_req == 2'b11) begin
            checks++; if (obs_id !== exp_id) begin errors++; $display("FAIL rand_id c%0d got=%h exp=%h", c, obs_id, exp_id); end
            checks++; if (obs_add !== exp_add) begin errors++; $display("FAIL rand_add c%0d got=%h exp=%h", c, obs_add, exp_add); end
            checks++; if (obs_last !== exp_last) begin errors++; $display("FAIL rand_last c%0d got=%b exp=%b", c, obs_last, exp_last); end
         end
         c++;
      end
      checks++; if (rq.size() + wq.size() !== 0) begin errors++; $display("FAIL rand_drain remaining=%0d exp=0", rq.size() + wq.size()); end
      checks++; if (beats_done !== pushed_beats) begin errors++; $display("FAIL rand_beats got=%0d exp=%0d", beats_done, pushed_beats); end
      rand_bp = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      zero_inputs();
      test_reset();
      test_read_single();
      test_contention();
      test_no_preempt();
      test_backpressure();
      test_protocol_error();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi2mem_tcdm_arbiter.md
# axi2mem_tcdm_arbiter

Shares the dual-lane TCDM command queue pair (two 32-bit word lanes per 64-bit beat) between the axi2mem read and write channels. Grants whole AXI bursts to one channel at a time, with round-robin fairness between the channels. Sits between the two channel blocks and the TCDM command queues. Tags each forwarded command with a write-enable and flags lane-protocol violations.

## Interface
- ID_WIDTH, 6: width of the per-lane transaction id.
- ADDR_WIDTH, 32: width of the per-lane TCDM address.
- clk_i  in  1  single clock; all state on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- rd_pend_i / wr_pend_i  in  1  channel has a transaction waiting (AR valid; AW valid and W valid).
- rd_trans_req_i / wr_trans_req_i  in  2  per-lane command request.
- rd_trans_id_i / wr_trans_id_i  in  2×ID_WIDTH  per-lane id.
- rd_trans_add_i / wr_trans_add_i  in  2×ADDR_WIDTH  per-lane address.
- rd_trans_last_i / wr_trans_last_i  in  2  per-lane last-beat flag.
- rd_trans_gnt_o / wr_trans_gnt_o  out  2  per-lane availability to the channel.
- trans_req_o  out  2  request to the command queues.
- trans_id_o  out  2×ID_WIDTH  id to the command queues.
- trans_add_o  out  2×ADDR_WIDTH  address to the command queues.
- trans_last_o  out  2  last flag to the command queues.
- trans_we_o  out  1  1 when the write channel owns the queues.
- trans_gnt_i  in  2  per-lane command-queue availability.
- owner_o  out  2  registered owner: 00 none, 01 read, 10 write.
- err_o  out  1  sticky protocol-error flag.

## Operation
- State machine with states IDLE, RD_OWN and WR_OWN. Additional registers: last_served (RD/WR) and in_burst.
- Reset values: state IDLE, last_served=WR (read wins the first tie), in_burst=0, err_o=0.
- Outputs during and immediately after reset: all gnt_o=00, trans_req_o=00, trans_we_o=0, owner_o=00.
- Arbitration happens in IDLE or at a release point:
  - only one pend asserted → that channel;
  - both asserted → the channel that is not last_served;
  - neither asserted → IDLE.
- Availability to the channels:
  - the owner's gnt_o equals trans_gnt_i;
  - the non-owner's gnt_o is 00.
  - gnt_o never depends combinationally on any req input, because the channels derive req from gnt.
- Forwarding: trans_req/id/add/last_o mux the owner's inputs; in IDLE they are all zero. trans_we_o = (state==WR_OWN).
- Beat handshake: owner req==11 and trans_gnt_i==11.
- Handshake with last==11:
  - end of burst: clear in_burst, set last_served to the owner, re-arbitrate for the next cycle;
  - the other channel has priority if its pend is asserted.
- Handshake with last!=11 sets in_burst.
- Owner releases without a beat when in_burst=0 and its pend is low: return to IDLE; last_served unchanged.
- A burst is never preempted while in_burst=1, regardless of the other channel's pend.
- err_o is set and held until reset on any of:
  - non-owner req!=00;
  - owner req of 01 or 10;
  - owner req==11 with last of 01 or 10.
  - Erroneous requests are not forwarded; the forwarded req is forced to 00 in that cycle.
- Reset asserted mid-burst: state returns to IDLE next edge; in-flight burst abandoned; no partial command forwarded after the reset edge.

## Timing
- pend → gnt_o: 1 cycle (owner is registered); command path: 0 cycles combinational.
- Back-to-back bursts from different channels: last beat at cycle N; new owner's gnt_o active at cycle N+1; no idle cycle.
- Same channel, other channel idle: continues at N+1 if its pend is high.
- Throughput: one beat (two lanes) per cycle while trans_gnt_i==11.

## Structure
- Package axi2mem_arb_pkg holds owner_e (NONE, RD, WR), the owner_o encoding and default widths (ID 6, ADDR 32).
- Sub-module axi2mem_rr_pick: 2-way round-robin chooser, combinational, taking pend[1:0] and last_served and returning the next owner.
- Arbiter RTL remains the state machine, the muxes and the error logic.

## Test plan
- Read single beat: rd_pend at cycle 0 → owner_o=01 and rd_gnt=11 at cycle 1; read req 11 with last 11, add 0x100/0x104 → forwarded with trans_we_o=0, IDLE at cycle 2.
- Contention: both pends high from reset → read served first; 4-beat write starts the cycle after the read's last beat; after the write, a still-pending read wins.
- No preemption: 8-beat write while rd_pend stays high → rd_gnt_o=00 for all 8 beats; read owner the cycle after beat 8.
- Backpressure: trans_gnt_i=01 during a burst → owner gnt 01, no beat counted; burst resumes when it returns to 11, no beat lost.
- Protocol error: the non-owner drives req=11 → err_o=1 next cycle and stays until rst_i; the queues see no request from it.
- Reset mid-burst: rst_i after 3 of 8 beats → all outputs zero, owner_o=00, err_o=0 after the edge.
